// File: rtl/crank_wheel_gen.sv
// crank_wheel_gen: missing-tooth crank wheel pattern generator (transmit end of vrin).
// Latency: enable sampled at edge N -> vr_out=1, tooth_idx=0, rev_strobe=1 after edge N+1.
// Backpressure: none; free-running square-wave train while enabled.
// Optional cam phase output enabled by macro CRANK_GEN_CAM_OUT_EN (cam_out tied 0 otherwise).
module crank_wheel_gen #(
  parameter int PERIOD_W = 32,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] tooth_period,
  input  logic [CNT_W-1:0]    conf_tooth_cnt,
  input  logic [CNT_W-1:0]    conf_teeth_missing,
  output logic                vr_out,
  output logic [CNT_W-1:0]    tooth_idx,
  output logic                rev_strobe,
  output logic                conf_err,
  output logic                cam_out
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // generator core: position within the wheel
  state_t              r_state;
  state_t              w_state_nxt;
  logic [PERIOD_W-1:0] r_cyc_cnt;
  logic [PERIOD_W-1:0] w_cyc_nxt;
  logic [PERIOD_W-1:0] r_p_lat;
  logic [PERIOD_W-1:0] w_p_lat_nxt;
  logic [CNT_W-1:0]    r_idx;
  logic [CNT_W-1:0]    w_idx_nxt;
  logic [CNT_W-1:0]    r_cnt_lat;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [CNT_W-1:0]    r_miss_lat;
  logic [CNT_W-1:0]    w_miss_nxt;
  logic                r_conf_err;
  logic                w_conf_err_nxt;

  // decodes of the core position
  logic                w_cfg_valid;
  logic [PERIOD_W-1:0] w_period_clamp;
  logic                w_slot_end;
  logic                w_last_slot;
  logic                w_present;
  logic                w_stop;
  logic                w_vr_core;
  logic                w_strobe_core;

  // output registers (one stage behind the core, no input-to-output path)
  logic                r_vr;
  logic [CNT_W-1:0]    r_tooth_idx;
  logic                r_rev_strobe;

  assign w_cfg_valid    = (conf_tooth_cnt >= CNT_W'(2)) && (conf_teeth_missing < conf_tooth_cnt);
  assign w_period_clamp = (tooth_period < PERIOD_W'(2)) ? PERIOD_W'(2) : tooth_period;
  assign w_slot_end     = (r_cyc_cnt == (r_p_lat - PERIOD_W'(1)));
  assign w_last_slot    = (r_idx == (r_cnt_lat - CNT_W'(1)));
  assign w_present      = (r_idx < (r_cnt_lat - r_miss_lat));
  // enable drop in RUN clears the outputs at the same edge the core goes idle
  assign w_stop         = (r_state == ST_RUN) && !enable;

  // next-state and waveform decode for the slot/tooth sequencer
  always_comb begin
    w_state_nxt    = r_state;
    w_cyc_nxt      = r_cyc_cnt;
    w_idx_nxt      = r_idx;
    w_p_lat_nxt    = r_p_lat;
    w_cnt_nxt      = r_cnt_lat;
    w_miss_nxt     = r_miss_lat;
    w_conf_err_nxt = r_conf_err;
    w_vr_core      = 1'b0;
    w_strobe_core  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (enable) begin
          if (w_cfg_valid) begin
            w_state_nxt    = ST_RUN;
            w_cyc_nxt      = '0;
            w_idx_nxt      = '0;
            w_p_lat_nxt    = w_period_clamp;
            w_cnt_nxt      = conf_tooth_cnt;
            w_miss_nxt     = conf_teeth_missing;
            w_conf_err_nxt = 1'b0;
          end else begin
            w_conf_err_nxt = 1'b1;
          end
        end
      end

      ST_RUN: begin
        // high phase is the first floor(p/2) cycles, so odd periods stay low one cycle longer
        w_vr_core     = w_present && (r_cyc_cnt < (r_p_lat >> 1));
        w_strobe_core = (r_idx == '0) && (r_cyc_cnt == '0);
        if (!enable) begin
          // dropping enable wins over any slot or revolution wrap this cycle
          w_state_nxt = ST_IDLE;
          w_cyc_nxt   = '0;
          w_idx_nxt   = '0;
        end else if (w_slot_end) begin
          w_cyc_nxt   = '0;
          w_p_lat_nxt = w_period_clamp;
          if (w_last_slot) begin
            w_idx_nxt = '0;
            // wheel geometry is only re-sampled between revolutions
            if (w_cfg_valid) begin
              w_cnt_nxt      = conf_tooth_cnt;
              w_miss_nxt     = conf_teeth_missing;
              w_conf_err_nxt = 1'b0;
            end else begin
              w_state_nxt    = ST_IDLE;
              w_conf_err_nxt = 1'b1;
            end
          end else begin
            w_idx_nxt = r_idx + CNT_W'(1);
          end
        end else begin
          w_cyc_nxt = r_cyc_cnt + PERIOD_W'(1);
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_cyc_nxt   = '0;
        w_idx_nxt   = '0;
      end
    endcase
  end

  // core state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_cyc_cnt  <= '0;
      r_p_lat    <= '0;
      r_idx      <= '0;
      r_cnt_lat  <= '0;
      r_miss_lat <= '0;
      r_conf_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cyc_cnt  <= w_cyc_nxt;
      r_p_lat    <= w_p_lat_nxt;
      r_idx      <= w_idx_nxt;
      r_cnt_lat  <= w_cnt_nxt;
      r_miss_lat <= w_miss_nxt;
      r_conf_err <= w_conf_err_nxt;
    end
  end

  // registered waveform outputs, forced low immediately when the run is stopped
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vr         <= 1'b0;
      r_tooth_idx  <= '0;
      r_rev_strobe <= 1'b0;
    end else if (w_stop) begin
      r_vr         <= 1'b0;
      r_tooth_idx  <= '0;
      r_rev_strobe <= 1'b0;
    end else begin
      r_vr         <= w_vr_core;
      r_tooth_idx  <= r_idx;
      r_rev_strobe <= w_strobe_core;
    end
  end

  assign vr_out     = r_vr;
  assign tooth_idx  = r_tooth_idx;
  assign rev_strobe = r_rev_strobe;
  assign conf_err   = r_conf_err;

`ifdef CRANK_GEN_CAM_OUT_EN
  logic r_rev_par;
  logic r_cam;
  logic w_run_entry;
  logic w_new_rev;
  logic w_cam_core;

  assign w_run_entry = (r_state == ST_IDLE) && (w_state_nxt == ST_RUN);
  assign w_new_rev   = (r_state == ST_RUN) && (w_state_nxt == ST_RUN) && w_slot_end && w_last_slot;
  // cam is high for slot 0 of every even revolution -> one pulse per 720 degrees
  assign w_cam_core  = (r_state == ST_RUN) && (r_idx == '0) && !r_rev_par;

  // revolution parity: even on the first revolution after entering RUN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rev_par <= 1'b0;
    end else if (w_run_entry) begin
      r_rev_par <= 1'b0;
    end else if (w_new_rev) begin
      r_rev_par <= ~r_rev_par;
    end
  end

  // cam output register, aligned with the other waveform outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cam <= 1'b0;
    end else if (w_stop) begin
      r_cam <= 1'b0;
    end else begin
      r_cam <= w_cam_core;
    end
  end

  assign cam_out = r_cam;
`else
  assign cam_out = 1'b0;
`endif

endmodule

// File: tb/tb_crank_wheel_gen.sv
// Bench for crank_wheel_gen: directed scenarios plus randomized configs against a wheel model.
// The model tracks (running, slot, cycles-into-slot, slot length, revolution) and predicts outputs.
// Literal measurements (run lengths, strobe/cam spacing) pin the model to the wheel geometry.
module tb_crank_wheel_gen;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        enable = 1'b0;
  logic [31:0] tooth_period = 32'd100;
  logic [15:0] conf_tooth_cnt = 16'd60;
  logic [15:0] conf_teeth_missing = 16'd2;
  logic        vr_out;
  logic [15:0] tooth_idx;
  logic        rev_strobe;
  logic        conf_err;
  logic        cam_out;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  crank_wheel_gen #(.PERIOD_W(32), .CNT_W(16)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .enable             (enable),
    .tooth_period       (tooth_period),
    .conf_tooth_cnt     (conf_tooth_cnt),
    .conf_teeth_missing (conf_teeth_missing),
    .vr_out             (vr_out),
    .tooth_idx          (tooth_idx),
    .rev_strobe         (rev_strobe),
    .conf_err           (conf_err),
    .cam_out            (cam_out)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic bit cfg_ok(input int c, input int m);
    return (c >= 2) && (m < c);
  endfunction

  function automatic longint clamp_p(input logic [31:0] p);
    return (p < 32'd2) ? 64'd2 : longint'(p);
  endfunction

  // ---------------- behavioural wheel model ----------------
  bit     m_run;
  int     m_slot, m_cnt, m_miss, m_rev, m_err;
  longint m_el, m_len;
  int     e_vr, e_idx, e_str, e_cam, e_err;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_run = 0; m_slot = 0; m_el = 0; m_len = 2; m_cnt = 0; m_miss = 0; m_rev = 0; m_err = 0;
      e_vr = 0; e_idx = 0; e_str = 0; e_cam = 0; e_err = 0;
    end else begin
      if (m_run && !enable) begin
        // stop: outputs low from this edge, no wrap or strobe
        m_run = 0; m_slot = 0; m_el = 0;
        e_vr = 0; e_idx = 0; e_str = 0; e_cam = 0;
      end else begin
        // outputs after this edge show the wheel position held during the last cycle
        e_vr  = (m_run && (m_slot < m_cnt - m_miss) && (m_el < m_len / 2)) ? 1 : 0;
        e_idx = m_run ? m_slot : 0;
        e_str = (m_run && m_slot == 0 && m_el == 0) ? 1 : 0;
`ifdef CRANK_GEN_CAM_OUT_EN
        e_cam = (m_run && m_slot == 0 && (m_rev % 2) == 0) ? 1 : 0;
`else
        e_cam = 0;
`endif
        if (!m_run) begin
          if (enable) begin
            if (cfg_ok(int'(conf_tooth_cnt), int'(conf_teeth_missing))) begin
              m_run = 1; m_slot = 0; m_el = 0; m_rev = 0; m_err = 0;
              m_len = clamp_p(tooth_period);
              m_cnt = int'(conf_tooth_cnt); m_miss = int'(conf_teeth_missing);
            end else begin
              m_err = 1;
            end
          end
        end else begin
          m_el++;
          if (m_el == m_len) begin
            m_el = 0;
            m_slot++;
            m_len = clamp_p(tooth_period);
            if (m_slot == m_cnt) begin
              m_slot = 0;
              if (cfg_ok(int'(conf_tooth_cnt), int'(conf_teeth_missing))) begin
                m_cnt = int'(conf_tooth_cnt); m_miss = int'(conf_teeth_missing);
                m_rev++; m_err = 0;
              end else begin
                m_run = 0; m_err = 1;
              end
            end
          end
        end
      end
      e_err = m_err;
    end
  end

  // ---------------- per-cycle compare and waveform measurements ----------------
  int cyc = 0;
  bit prev_vr = 0;
  int high_run = 0, low_run = 0, last_high = 0, last_low = 0, max_low = 0;
  int prev_idx = 0, idx_t = 0, last_slot_len = 0;
  int last_str = 0, strobe_gap = 0;
  bit prev_cam = 0;
  int cam_run = 0, cam_last_high = 0, last_cam_rise = 0, cam_gap = 0, cam_high_total = 0;

  always @(negedge clk) begin
    cyc++;
    chk("vr_out", longint'(vr_out), longint'(e_vr));
    chk("tooth_idx", longint'(tooth_idx), longint'(e_idx));
    chk("rev_strobe", longint'(rev_strobe), longint'(e_str));
    chk("cam_out", longint'(cam_out), longint'(e_cam));
    chk("conf_err", longint'(conf_err), longint'(e_err));

    if (vr_out) begin
      if (!prev_vr) begin
        last_low = low_run;
        if (low_run > max_low) max_low = low_run;
        high_run = 0;
      end
      high_run++;
    end else begin
      if (prev_vr) begin
        last_high = high_run;
        low_run = 0;
      end
      low_run++;
    end
    prev_vr = vr_out;

    if (int'(tooth_idx) != prev_idx) begin
      last_slot_len = cyc - idx_t;
      idx_t = cyc;
    end
    prev_idx = int'(tooth_idx);

    if (rev_strobe) begin
      strobe_gap = cyc - last_str;
      last_str = cyc;
    end

    if (cam_out) begin
      cam_high_total++;
      if (!prev_cam) begin
        cam_gap = cyc - last_cam_rise;
        last_cam_rise = cyc;
        cam_run = 0;
      end
      cam_run++;
    end else if (prev_cam) begin
      cam_last_high = cam_run;
    end
    prev_cam = cam_out;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idx(input int target, input int budget);
    int n = 0;
    while (int'(tooth_idx) != target && n < budget) begin
      tick();
      n++;
    end
    chk("wait_tooth_idx", longint'(tooth_idx), longint'(target));
  endtask

  task automatic wait_err(input int budget);
    int n = 0;
    while (!conf_err && n < budget) begin
      tick();
      n++;
    end
    chk("wait_conf_err", longint'(conf_err), 1);
  endtask

  initial begin
    int hi_cnt;
    #1 reset_n = 1'b0;
    #1;
    chk("reset_vr", longint'(vr_out), 0);
    chk("reset_idx", longint'(tooth_idx), 0);
    chk("reset_strobe", longint'(rev_strobe), 0);
    chk("reset_err", longint'(conf_err), 0);
    chk("reset_cam", longint'(cam_out), 0);
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // 60-2 at 100 cycles per slot, with start latency pinned
    enable = 1'b1;
    tick();
    chk("latency_vr_early", longint'(vr_out), 0);
    chk("latency_strobe_early", longint'(rev_strobe), 0);
    tick();
    chk("latency_vr", longint'(vr_out), 1);
    chk("latency_strobe", longint'(rev_strobe), 1);
    chk("latency_idx", longint'(tooth_idx), 0);
    max_low = 0;
    repeat (12100) tick();
    chk("t1_strobe_gap", strobe_gap, 6000);
    chk("t1_high_run", last_high, 50);
    chk("t1_gap_low_run", max_low, 250);

    // period change mid-slot 10 takes effect at slot 11
    wait_idx(10, 7000);
    repeat (30) tick();
    tooth_period = 32'd40;
    wait_idx(11, 200);
    chk("t2_slot10_len", last_slot_len, 100);
    wait_idx(12, 200);
    chk("t2_slot11_len", last_slot_len, 40);
    chk("t2_high", last_high, 20);
    chk("t2_low", last_low, 20);

    // period 0 and 1 clamp to 2
    tooth_period = 32'd0;
    wait_idx(20, 500);
    wait_idx(21, 50);
    chk("t3_p0_len", last_slot_len, 2);
    chk("t3_p0_high", last_high, 1);
    chk("t3_p0_low", last_low, 1);
    tooth_period = 32'd1;
    wait_idx(30, 100);
    wait_idx(31, 50);
    chk("t3_p1_len", last_slot_len, 2);

    // all slots missing -> invalid at the rev boundary, stays idle
    conf_teeth_missing = 16'd60;
    wait_err(500);
    hi_cnt = 0;
    repeat (50) begin
      tick();
      if (vr_out) hi_cnt++;
    end
    chk("t4_vr_quiet", hi_cnt, 0);
    chk("t4_err_held", longint'(conf_err), 1);
    conf_teeth_missing = 16'd1;
    tooth_period = 32'd100;
    tick();
    chk("t4_err_clear", longint'(conf_err), 0);
    tick();
    chk("t4_restart_vr", longint'(vr_out), 1);
    chk("t4_restart_strobe", longint'(rev_strobe), 1);
    chk("t4_restart_idx", longint'(tooth_idx), 0);

    // async reset at slot 30
    wait_idx(30, 4000);
    repeat (5) tick();
    reset_n = 1'b0;
    #1;
    chk("t5_rst_vr", longint'(vr_out), 0);
    chk("t5_rst_idx", longint'(tooth_idx), 0);
    chk("t5_rst_strobe", longint'(rev_strobe), 0);
    tick(); tick();
    reset_n = 1'b1;
    // enable drop at slot 30, cycle 10
    wait_idx(30, 4000);
    repeat (10) tick();
    chk("t5_pre_drop_vr", longint'(vr_out), 1);
    enable = 1'b0;
    tick();
    chk("t5_drop_vr", longint'(vr_out), 0);
    chk("t5_drop_idx", longint'(tooth_idx), 0);
    tick();

    // 36-1 at 10 cycles per slot: cam pulse every other revolution
    conf_tooth_cnt = 16'd36;
    conf_teeth_missing = 16'd1;
    tooth_period = 32'd10;
    cam_high_total = 0;
    tick();
    enable = 1'b1;
    repeat (2200) tick();
    chk("t6_strobe_gap", strobe_gap, 360);
`ifdef CRANK_GEN_CAM_OUT_EN
    chk("t6_cam_gap", cam_gap, 720);
    chk("t6_cam_high", cam_last_high, 10);
`else
    chk("t6_cam_never", cam_high_total, 0);
`endif

    // randomized configurations, enable toggles and period changes
    for (int ep = 0; ep < 30; ep++) begin
      int c;
      c = int'($urandom_range(1, 8));
      conf_tooth_cnt = 16'(c);
      conf_teeth_missing = 16'($urandom_range(0, c));
      tooth_period = 32'($urandom_range(0, 6));
      enable = ($urandom_range(0, 9) != 0);
      for (int k = 0; k < int'($urandom_range(20, 200)); k++) begin
        tick();
        if ($urandom_range(0, 49) == 0) enable = ~enable;
        if ($urandom_range(0, 29) == 0) tooth_period = 32'($urandom_range(0, 6));
      end
    end
    enable = 1'b0;
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
